cond_pipe_ctrl: RTL
===================

Name: cond_pipe_ctrl

Overview:
- Parametrised pipelined control-signal carrier for the ARM-subset core.
- Takes decoded control bundle in Decode and registers it through Execute plus NPOST post-execute stages (default Memory, Writeback).
- In Execute: evaluates the condition field against the architectural flags, gates side effects, and updates flags under mask.
- Successor to the fixed D/E/M/W controller; adds per-stage stall/flush, configurable depth, a generic execute payload, and full 15-code condition evaluation.

Parameters:
- NPOST, 2, number of stages after Execute (>=1); last stage is Writeback.
- EPW, 4, width of execute-only payload (ALU control + ALU source select), consumed in E and not carried further.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD  in  1 each  decoded control.
- FlagWriteD  in  2  [1]=update N,Z; [0]=update C,V.
- CondD  in  4  condition field.
- EPayD  in  EPW  execute payload.
- StallE  in  1  hold E stage.
- FlushE  in  1  bubble into E.
- FlushM  in  1  bubble into first post stage.
- ALUFlags  in  4  {N,Z,C,V} from ALU in E.
- EPayE  out  EPW  registered payload.
- MemtoRegE  out  1  for load-use detection.
- BranchTakenE  out  1  BranchE & CondExE.
- CondExE  out  1  condition result.
- FlagsE  out  4  architectural flags.
- PCSrcV, RegWriteV, MemtoRegV  out  NPOST each  per post-stage bits; index 0 = M, NPOST-1 = W.
- MemWriteM  out  1  stage-0 memory write.
- PCWrPendingF  out  1  PC write in flight.

Behaviour:
- Reset (sync): all E and post-stage registers cleared to 0, FlagsE=0. All outputs 0 the cycle after reset is sampled. Reset mid-stream discards in-flight bundles.
- E register update per edge:
  - FlushE: clear.
  - else StallE: hold.
  - else: load D bundle.
  - FlushE has priority over StallE.
- Condition eval (combinational on CondE, FlagsE):
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - AL(1110)=1; 1111=0.
- Gating: PCSrc, RegWrite, MemWrite, and FlagWrite bits are ANDed with CondExE before leaving E. MemtoReg and Branch are not gated.
- Flags update: on edge when ~StallE & ~reset.
  - N,Z <- ALUFlags[3:2] if gated FlagWrite[1].
  - C,V <- ALUFlags[1:0] if gated FlagWrite[0].
  - Otherwise hold.
  - A stalled E instruction updates flags exactly once, on its release cycle.
- Post stage 0 per edge:
  - FlushM | StallE: load zeros (bubble).
  - else: load gated E outputs.
- Post stage k>0: unconditionally copies stage k-1 (no stall).
- Latency: a D bundle appears at E outputs 1 cycle later and at stage k k+2 cycles later, absent stall/flush.
- PCWrPendingF = PCSrcD | PCSrcE(ungated) | OR of PCSrcV[0..NPOST-2]. Excludes W. With NPOST=1 this is PCSrcD|PCSrcE.
- Simultaneous FlushE and StallE: E clears, stage 0 gets a bubble.
- Flags are not affected by FlushE or FlushM.

Decomposition:
- Shared package (arm_ctrl_pkg):
  - Condition-code constants COND_EQ..COND_NV.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Control-bundle field widths.
- Sub-module cond_eval: combinational; inputs Cond[3:0], Flags[3:0]; output CondEx.
- Post stages built with a generate loop over floprc/flopr.

Test Plan:
- Basic flow, NPOST=2: RegWriteD=1, CondD=1110 for one cycle -> RegWriteV[0]=1 two edges later, RegWriteV[1]=1 three edges later, then 0.
- Conditional squash: FlagsE=0100 (Z=1), E holds CondE=0001 (NE), MemWriteE=1, RegWriteE=1 -> CondExE=0, MemWriteM=0 and RegWriteV[0]=0 next cycle.
- Flag mask: FlagWriteE=10, AL, ALUFlags=1111, FlagsE=0000 -> FlagsE=1100. Then FlagWriteE=01, ALUFlags=0011 -> FlagsE=1111.
- Stall: StallE=1 for 2 cycles with FlagWriteE=11 and ALUFlags=1010 -> E held, stage 0 gets 2 bubbles, FlagsE unchanged until the release edge, then =1010 exactly once.
- Flush priority and PC pending: PCSrcD=1 -> PCWrPendingF=1. Next cycle FlushE=1 and StallE=1 -> PCSrcE=0, PCSrcV all 0, PCWrPendingF=0 once PCSrcD=0.
- Branch and signed compare: FlagsE=1000 (N=1,V=0), BranchE=1, CondE=1011 (LT) -> BranchTakenE=1. CondE=1100 (GT) -> BranchTakenE=0. CondE=1111 -> 0. Reset asserted mid-sequence -> all outputs 0 next cycle.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared constants for the ARM-subset control path: condition codes,
// flag bit positions and control-bundle field widths.
package arm_ctrl_pkg;

    localparam int unsigned COND_W   = 4;
    localparam int unsigned FLAGS_W  = 4;
    localparam int unsigned FLAGWR_W = 2;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;
    localparam logic [COND_W-1:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a 4-bit condition field against {N,Z,C,V}.
module cond_eval
    import arm_ctrl_pkg::*;
(
    input  logic [COND_W-1:0]  Cond,
    input  logic [FLAGS_W-1:0] Flags,
    output logic               CondEx
);

    logic w_n, w_z, w_c, w_v, w_ge;

    assign w_n  = Flags[FLAG_N];
    assign w_z  = Flags[FLAG_Z];
    assign w_c  = Flags[FLAG_C];
    assign w_v  = Flags[FLAG_V];
    assign w_ge = (w_n == w_v);

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = w_z;
            COND_NE: CondEx = ~w_z;
            COND_CS: CondEx = w_c;
            COND_CC: CondEx = ~w_c;
            COND_MI: CondEx = w_n;
            COND_PL: CondEx = ~w_n;
            COND_VS: CondEx = w_v;
            COND_VC: CondEx = ~w_v;
            COND_HI: CondEx = w_c & ~w_z;
            COND_LS: CondEx = ~w_c | w_z;
            COND_GE: CondEx = w_ge;
            COND_LT: CondEx = ~w_ge;
            COND_GT: CondEx = ~w_z & w_ge;
            COND_LE: CondEx = w_z | ~w_ge;
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_pipe_ctrl.sv
// Pipelined control carrier: Decode bundle -> Execute (condition check,
// flag update, gating) -> NPOST post-execute stages ending in Writeback.
module cond_pipe_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int unsigned NPOST = 2,
    parameter int unsigned EPW   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                PCSrcD,
    input  logic                RegWriteD,
    input  logic                MemtoRegD,
    input  logic                MemWriteD,
    input  logic                BranchD,
    input  logic [FLAGWR_W-1:0] FlagWriteD,
    input  logic [COND_W-1:0]   CondD,
    input  logic [EPW-1:0]      EPayD,
    input  logic                StallE,
    input  logic                FlushE,
    input  logic                FlushM,
    input  logic [FLAGS_W-1:0]  ALUFlags,
    output logic [EPW-1:0]      EPayE,
    output logic                MemtoRegE,
    output logic                BranchTakenE,
    output logic                CondExE,
    output logic [FLAGS_W-1:0]  FlagsE,
    output logic [NPOST-1:0]    PCSrcV,
    output logic [NPOST-1:0]    RegWriteV,
    output logic [NPOST-1:0]    MemtoRegV,
    output logic                MemWriteM,
    output logic                PCWrPendingF
);

    logic                r_pcsrc_e, r_regwrite_e, r_memtoreg_e, r_memwrite_e, r_branch_e;
    logic [FLAGWR_W-1:0] r_flagwrite_e;
    logic [COND_W-1:0]   r_cond_e;
    logic [EPW-1:0]      r_epay_e;
    logic [FLAGS_W-1:0]  r_flags;

    logic [NPOST-1:0]    r_pcsrc_v, r_regwrite_v, r_memtoreg_v;
    logic                r_memwrite_m;

    logic                w_condex;
    logic                w_pcsrc_g, w_regwrite_g, w_memwrite_g;
    logic [FLAGWR_W-1:0] w_flagwrite_g;
    logic [NPOST-1:0]    w_pcsrc_nxt, w_regwrite_nxt, w_memtoreg_nxt;
    logic                w_bubble_m;
    logic                w_pend_post;

    // Execute register: flush beats stall
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            r_pcsrc_e     <= 1'b0;
            r_regwrite_e  <= 1'b0;
            r_memtoreg_e  <= 1'b0;
            r_memwrite_e  <= 1'b0;
            r_branch_e    <= 1'b0;
            r_flagwrite_e <= '0;
            r_cond_e      <= '0;
            r_epay_e      <= '0;
        end else if (!StallE) begin
            r_pcsrc_e     <= PCSrcD;
            r_regwrite_e  <= RegWriteD;
            r_memtoreg_e  <= MemtoRegD;
            r_memwrite_e  <= MemWriteD;
            r_branch_e    <= BranchD;
            r_flagwrite_e <= FlagWriteD;
            r_cond_e      <= CondD;
            r_epay_e      <= EPayD;
        end
    end

    cond_eval u_cond_eval (
        .Cond   (r_cond_e),
        .Flags  (r_flags),
        .CondEx (w_condex)
    );

    assign w_pcsrc_g     = r_pcsrc_e & w_condex;
    assign w_regwrite_g  = r_regwrite_e & w_condex;
    assign w_memwrite_g  = r_memwrite_e & w_condex;
    assign w_flagwrite_g = r_flagwrite_e & {FLAGWR_W{w_condex}};

    // Stalled instruction commits its flags only on the release edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else if (!StallE) begin
            if (w_flagwrite_g[1]) begin
                r_flags[FLAG_N] <= ALUFlags[FLAG_N];
                r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (w_flagwrite_g[0]) begin
                r_flags[FLAG_C] <= ALUFlags[FLAG_C];
                r_flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // Post-stage shift: stage 0 takes gated E outputs or a bubble, later stages copy
    assign w_bubble_m = FlushM | StallE;

    always_comb begin
        w_pcsrc_nxt       = r_pcsrc_v << 1;
        w_regwrite_nxt    = r_regwrite_v << 1;
        w_memtoreg_nxt    = r_memtoreg_v << 1;
        w_pcsrc_nxt[0]    = w_pcsrc_g & ~w_bubble_m;
        w_regwrite_nxt[0] = w_regwrite_g & ~w_bubble_m;
        w_memtoreg_nxt[0] = r_memtoreg_e & ~w_bubble_m;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcsrc_v    <= '0;
            r_regwrite_v <= '0;
            r_memtoreg_v <= '0;
            r_memwrite_m <= 1'b0;
        end else begin
            r_pcsrc_v    <= w_pcsrc_nxt;
            r_regwrite_v <= w_regwrite_nxt;
            r_memtoreg_v <= w_memtoreg_nxt;
            r_memwrite_m <= w_memwrite_g & ~w_bubble_m;
        end
    end

    // Writeback is excluded: its PC write lands this cycle
    generate
        if (NPOST > 1) begin : g_pend
            assign w_pend_post = |r_pcsrc_v[NPOST-2:0];
        end else begin : g_no_pend
            assign w_pend_post = 1'b0;
        end
    endgenerate

    assign PCWrPendingF = PCSrcD | r_pcsrc_e | w_pend_post;
    assign EPayE        = r_epay_e;
    assign MemtoRegE    = r_memtoreg_e;
    assign BranchTakenE = r_branch_e & w_condex;
    assign CondExE      = w_condex;
    assign FlagsE       = r_flags;
    assign PCSrcV       = r_pcsrc_v;
    assign RegWriteV    = r_regwrite_v;
    assign MemtoRegV    = r_memtoreg_v;
    assign MemWriteM    = r_memwrite_m;

endmodule
